// File: rtl/conv_ctrl.sv
// conv_ctrl: sequencing FSM for the 2-D valid convolution datapath.
// Turns load_h / load_x / start commands into memory write enables,
// tap addresses and MAC controls, then streams the output memory out.
// Holds no data: only the latched geometry, counters and control flops.
module conv_ctrl #(
    parameter int K_AW = 6,
    parameter int X_AW = 20,
    parameter int O_AW = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [9:0]      I,
    input  logic [2:0]      K,
    input  logic            load_h,
    input  logic            load_x,
    input  logic            start,
    output logic            we_k,
    output logic [K_AW-1:0] addr_k,
    output logic            we_x,
    output logic [X_AW-1:0] addr_x,
    output logic            acc_en,
    output logic            acc_first,
    output logic            we_o,
    output logic            rd_o,
    output logic [O_AW-1:0] addr_o,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_X,
        S_CALC,
        S_DONE,
        S_READ
    } state_t;

    state_t          state_q, state_d;

    // Geometry latched when a command is accepted
    logic [9:0]      i_q, i_d;
    logic [2:0]      k_q, k_d;
    logic [K_AW-1:0] kk_q, kk_d;
    logic [X_AW-1:0] ii_q, ii_d;
    logic [9:0]      m_q, m_d;
    logic [O_AW-1:0] nn_q, nn_d;

    // Tap position (ti, tj) and output position (r, c)
    logic [2:0]      ti_q, ti_d, tj_q, tj_d;
    logic [9:0]      r_q, r_d, c_q, c_d;

    // outBase = r*I + c, rowBase = (r+i)*I + c, kept by incremental adds
    logic [X_AW-1:0] outBase_q, outBase_d;
    logic [X_AW-1:0] rowBase_q, rowBase_d;

    // Tap pipeline: issue (cycle n) -> acc stage (n+1) -> write stage (n+2)
    logic            issue_q, issue_d;
    logic            last1_q, last1_d;
    logic [O_AW-1:0] wcnt_q, wcnt_d;

    // Registered outputs
    logic            we_k_q, we_k_d;
    logic [K_AW-1:0] addr_k_q, addr_k_d;
    logic            we_x_q, we_x_d;
    logic [X_AW-1:0] addr_x_q, addr_x_d;
    logic            acc_en_q, acc_en_d;
    logic            acc_first_q, acc_first_d;
    logic            we_o_q, we_o_d;
    logic            rd_o_q, rd_o_d;
    logic [O_AW-1:0] addr_o_q, addr_o_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Command-time geometry helpers (evaluated only when a command is accepted)
    logic [5:0]      kSq;
    logic [19:0]     iSq;
    logic [9:0]      mPin;
    logic [19:0]     mSq;
    logic            cmdValid;

    // Tap / output position flags
    logic [2:0]      kLast;
    logic            tapRowEnd, tapLast, outRowEnd, outLast;
    logic [X_AW-1:0] iExt, kExt, nextBase;

    assign kSq      = {3'b000, K} * {3'b000, K};
    assign iSq      = {10'd0, I} * {10'd0, I};
    assign mPin     = I - {7'd0, K} + 10'd1;
    assign mSq      = {10'd0, mPin} * {10'd0, mPin};
    assign cmdValid = (I != 10'd0) && (K != 3'd0) && ({7'd0, K} <= I);

    assign kLast     = k_q - 3'd1;
    assign tapRowEnd = (tj_q == kLast);
    assign tapLast   = tapRowEnd && (ti_q == kLast);
    assign outRowEnd = (c_q == m_q - 10'd1);
    assign outLast   = outRowEnd && (r_q == m_q - 10'd1);
    assign iExt      = X_AW'(i_q);
    assign kExt      = X_AW'(k_q);

    // State register and all counters/output flops; reset aborts at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            k_q         <= '0;
            kk_q        <= '0;
            ii_q        <= '0;
            m_q         <= '0;
            nn_q        <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            outBase_q   <= '0;
            rowBase_q   <= '0;
            issue_q     <= 1'b0;
            last1_q     <= 1'b0;
            wcnt_q      <= '0;
            we_k_q      <= 1'b0;
            addr_k_q    <= '0;
            we_x_q      <= 1'b0;
            addr_x_q    <= '0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            we_o_q      <= 1'b0;
            rd_o_q      <= 1'b0;
            addr_o_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            kk_q        <= kk_d;
            ii_q        <= ii_d;
            m_q         <= m_d;
            nn_q        <= nn_d;
            ti_q        <= ti_d;
            tj_q        <= tj_d;
            r_q         <= r_d;
            c_q         <= c_d;
            outBase_q   <= outBase_d;
            rowBase_q   <= rowBase_d;
            issue_q     <= issue_d;
            last1_q     <= last1_d;
            wcnt_q      <= wcnt_d;
            we_k_q      <= we_k_d;
            addr_k_q    <= addr_k_d;
            we_x_q      <= we_x_d;
            addr_x_q    <= addr_x_d;
            acc_en_q    <= acc_en_d;
            acc_first_q <= acc_first_d;
            we_o_q      <= we_o_d;
            rd_o_q      <= rd_o_d;
            addr_o_q    <= addr_o_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic; addresses hold, enables default low
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        k_d         = k_q;
        kk_d        = kk_q;
        ii_d        = ii_q;
        m_d         = m_q;
        nn_d        = nn_q;
        ti_d        = ti_q;
        tj_d        = tj_q;
        r_d         = r_q;
        c_d         = c_q;
        outBase_d   = outBase_q;
        rowBase_d   = rowBase_q;
        nextBase    = outBase_q;
        wcnt_d      = wcnt_q;
        addr_k_d    = addr_k_q;
        addr_x_d    = addr_x_q;
        addr_o_d    = addr_o_q;
        issue_d     = 1'b0;
        we_k_d      = 1'b0;
        we_x_d      = 1'b0;
        we_o_d      = 1'b0;
        rd_o_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        acc_en_d    = issue_q;
        acc_first_d = issue_q && (ti_q == 3'd0) && (tj_q == 3'd0);
        last1_d     = issue_q && tapLast;

        case (state_q)
            S_IDLE: begin
                if (load_h || load_x || start) begin
                    i_d  = I;
                    k_d  = K;
                    kk_d = K_AW'(kSq);
                    ii_d = X_AW'(iSq);
                    m_d  = mPin;
                    nn_d = O_AW'(mSq);
                end
                if (load_h) begin
                    if (K != 3'd0) begin
                        state_d  = S_LOAD_K;
                        we_k_d   = 1'b1;
                        addr_k_d = '0;
                    end
                end else if (load_x) begin
                    if (I != 10'd0) begin
                        state_d  = S_LOAD_X;
                        we_x_d   = 1'b1;
                        addr_x_d = '0;
                    end
                end else if (start) begin
                    if (cmdValid) begin
                        state_d   = S_CALC;
                        issue_d   = 1'b1;
                        ti_d      = '0;
                        tj_d      = '0;
                        r_d       = '0;
                        c_d       = '0;
                        outBase_d = '0;
                        rowBase_d = '0;
                        wcnt_d    = '0;
                        addr_k_d  = '0;
                        addr_x_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD_K: begin
                if (addr_k_q == kk_q - K_AW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    we_k_d   = 1'b1;
                    addr_k_d = addr_k_q + K_AW'(1);
                end
            end

            S_LOAD_X: begin
                if (addr_x_q == ii_q - X_AW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    we_x_d   = 1'b1;
                    addr_x_d = addr_x_q + X_AW'(1);
                end
            end

            S_CALC: begin
                we_o_d = last1_q;
                if (last1_q) begin
                    addr_o_d = wcnt_q;
                    wcnt_d   = wcnt_q + O_AW'(1);
                end
                if (issue_q) begin
                    if (!tapRowEnd) begin
                        issue_d  = 1'b1;
                        tj_d     = tj_q + 3'd1;
                        addr_k_d = addr_k_q + K_AW'(1);
                        addr_x_d = addr_x_q + X_AW'(1);
                    end else if (!tapLast) begin
                        issue_d   = 1'b1;
                        tj_d      = '0;
                        ti_d      = ti_q + 3'd1;
                        addr_k_d  = addr_k_q + K_AW'(1);
                        rowBase_d = rowBase_q + iExt;
                        addr_x_d  = rowBase_q + iExt;
                    end else if (!outLast) begin
                        issue_d  = 1'b1;
                        ti_d     = '0;
                        tj_d     = '0;
                        addr_k_d = '0;
                        if (!outRowEnd) begin
                            c_d      = c_q + 10'd1;
                            nextBase = outBase_q + X_AW'(1);
                        end else begin
                            c_d      = '0;
                            r_d      = r_q + 10'd1;
                            nextBase = outBase_q + kExt;
                        end
                        outBase_d = nextBase;
                        rowBase_d = nextBase;
                        addr_x_d  = nextBase;
                    end
                end
                if (we_o_q && (addr_o_q == nn_q - O_AW'(1))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d  = S_READ;
                rd_o_d   = 1'b1;
                addr_o_d = '0;
            end

            S_READ: begin
                if (addr_o_q == nn_q - O_AW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    rd_o_d   = 1'b1;
                    addr_o_d = addr_o_q + O_AW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign we_k      = we_k_q;
    assign addr_k    = addr_k_q;
    assign we_x      = we_x_q;
    assign addr_x    = addr_x_q;
    assign acc_en    = acc_en_q;
    assign acc_first = acc_first_q;
    assign we_o      = we_o_q;
    assign rd_o      = rd_o_q;
    assign addr_o    = addr_o_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: scoreboard bench for conv_ctrl. Expected events are queued
// when a command is driven; a negedge monitor queues what the DUT does.
module tb_conv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  I;
    logic [2:0]  K;
    logic        load_h, load_x, start;
    logic        we_k, we_x, acc_en, acc_first, we_o, rd_o, busy, done, err;
    logic [5:0]  addr_k;
    logic [19:0] addr_x, addr_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] cy;
        logic [19:0] a;
        logic [6:0]  b;
    } ev_t;

    localparam int EV_WK = 1, EV_WX = 2, EV_ACC = 3, EV_WO = 4;
    localparam int EV_DONE = 5, EV_RD = 6, EV_ERR = 7, EV_STRAY = 8;

    ev_t expQ[$];
    ev_t obsQ[$];
    logic [5:0]  prevAk;
    logic [19:0] prevAx;

    conv_ctrl #(.K_AW(6), .X_AW(20), .O_AW(20)) dut (
        .clk(clk), .reset(reset), .I(I), .K(K),
        .load_h(load_h), .load_x(load_x), .start(start),
        .we_k(we_k), .addr_k(addr_k), .we_x(we_x), .addr_x(addr_x),
        .acc_en(acc_en), .acc_first(acc_first), .we_o(we_o), .rd_o(rd_o),
        .addr_o(addr_o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(input int kind, input int cy, input int a, input int b);
        ev_t e;
        e.kind = kind[3:0];
        e.cy   = cy[31:0];
        e.a    = a[19:0];
        e.b    = b[6:0];
        return e;
    endfunction

    // Monitor: records every DUT action with its cycle relative to the command edge
    always @(negedge clk) begin
        int rel;
        rel = cyc - base + 1;
        if (!reset) begin
            if (we_k)               obsQ.push_back(mkEv(EV_WK, rel, int'(addr_k), 0));
            if (we_x)               obsQ.push_back(mkEv(EV_WX, rel, int'(addr_x), 0));
            if (acc_en)             obsQ.push_back(mkEv(EV_ACC, rel, int'(prevAx), int'({prevAk, acc_first})));
            if (we_o)               obsQ.push_back(mkEv(EV_WO, rel, int'(addr_o), 0));
            if (done)               obsQ.push_back(mkEv(EV_DONE, rel, 0, 0));
            if (rd_o)               obsQ.push_back(mkEv(EV_RD, rel, int'(addr_o), 0));
            if (err)                obsQ.push_back(mkEv(EV_ERR, rel, 0, 0));
            if (acc_first && !acc_en) obsQ.push_back(mkEv(EV_STRAY, rel, 0, 0));
        end
        prevAk = addr_k;
        prevAx = addr_x;
    end

    task automatic applyStimulus(input logic [9:0] iv, input logic [2:0] kv,
                                 input logic lh, input logic lx, input logic st);
        @(negedge clk);
        expQ.delete();
        obsQ.delete();
        I = iv; K = kv; load_h = lh; load_x = lx; start = st;
        base = cyc + 1;
        @(posedge clk);
        #1;
        load_h = 1'b0; load_x = 1'b0; start = 1'b0;
        I = 10'd7; K = 3'd2;
    endtask

    task automatic waitIdle(input int limit, output int idleCy, output bit timedOut);
        timedOut = 1'b1;
        idleCy   = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!busy) begin
                idleCy   = cyc - base + 1;
                timedOut = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({we_k, we_x, acc_en, acc_first, we_o, rd_o, busy, done, err} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_enables got=%b want=0",
                     {we_k, we_x, acc_en, acc_first, we_o, rd_o, busy, done, err});
        end
        checks++;
        if ({addr_k, addr_x, addr_o} !== 46'd0) begin
            errors++;
            $display("[TB] FAIL reset_addrs got k=%0d x=%0d o=%0d want 0", addr_k, addr_x, addr_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_load(input string name, input logic [9:0] iv, input logic [2:0] kv,
                             input logic isX, input logic withStart);
        int n, idleCy;
        bit timedOut;
        n = isX ? int'(iv) * int'(iv) : int'(kv) * int'(kv);
        applyStimulus(iv, kv, !isX, isX, withStart);
        for (int t = 0; t < n; t++)
            expQ.push_back(mkEv(isX ? EV_WX : EV_WK, t + 1, t, 0));
        waitIdle(2000, idleCy, timedOut);
        checks++;
        if (timedOut || idleCy != n + 1) begin
            errors++;
            $display("[TB] FAIL %s busy_drop got cycle=%0d timeout=%0d want cycle=%0d", name, idleCy, timedOut, n + 1);
        end
        for (int e = 0; e < ((expQ.size() > obsQ.size()) ? expQ.size() : obsQ.size()); e++) begin
            checks++;
            if (e >= obsQ.size() || e >= expQ.size() || obsQ[e] !== expQ[e]) begin
                errors++;
                $display("[TB] FAIL %s ev%0d got %h want %h (n_got=%0d n_want=%0d)", name, e,
                         (e < obsQ.size()) ? obsQ[e] : '0, (e < expQ.size()) ? expQ[e] : '0,
                         obsQ.size(), expQ.size());
            end
        end
    endtask

    task automatic test_conv(input string name, input logic [9:0] iv, input logic [2:0] kv);
        int kk, m, nTaps, lastCy, idleCy;
        bit timedOut;
        int tapA[$];
        int tapB[$];
        kk = int'(kv) * int'(kv);
        m = int'(iv) - int'(kv) + 1;
        nTaps = m * m * kk;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
                for (int i = 0; i < int'(kv); i++)
                    for (int j = 0; j < int'(kv); j++) begin
                        tapA.push_back((r + i) * int'(iv) + c + j);
                        tapB.push_back(((i * int'(kv) + j) << 1) | ((i == 0 && j == 0) ? 1 : 0));
                    end
        applyStimulus(iv, kv, 1'b0, 1'b0, 1'b1);
        lastCy = nTaps + 3 + m * m;
        for (int cy = 1; cy <= lastCy; cy++) begin
            if (cy >= 2 && cy - 2 < nTaps)
                expQ.push_back(mkEv(EV_ACC, cy, tapA[cy - 2], tapB[cy - 2]));
            if (cy >= kk + 2 && (cy - 2) % kk == 0 && (cy - 2) / kk <= m * m)
                expQ.push_back(mkEv(EV_WO, cy, (cy - 2) / kk - 1, 0));
            if (cy == nTaps + 3)
                expQ.push_back(mkEv(EV_DONE, cy, 0, 0));
            if (cy >= nTaps + 4)
                expQ.push_back(mkEv(EV_RD, cy, cy - nTaps - 4, 0));
        end
        waitIdle(5000, idleCy, timedOut);
        checks++;
        if (timedOut || idleCy != lastCy + 1) begin
            errors++;
            $display("[TB] FAIL %s busy_drop got cycle=%0d timeout=%0d want cycle=%0d", name, idleCy, timedOut, lastCy + 1);
        end
        for (int e = 0; e < ((expQ.size() > obsQ.size()) ? expQ.size() : obsQ.size()); e++) begin
            checks++;
            if (e >= obsQ.size() || e >= expQ.size() || obsQ[e] !== expQ[e]) begin
                errors++;
                $display("[TB] FAIL %s ev%0d got %h want %h (n_got=%0d n_want=%0d)", name, e,
                         (e < obsQ.size()) ? obsQ[e] : '0, (e < expQ.size()) ? expQ[e] : '0,
                         obsQ.size(), expQ.size());
            end
        end
    endtask

    task automatic test_bad_start(input string name, input logic [9:0] iv, input logic [2:0] kv);
        applyStimulus(iv, kv, 1'b0, 1'b0, 1'b1);
        expQ.push_back(mkEv(EV_ERR, 1, 0, 0));
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s busy cycle %0d got=%b want=0", name, n + 1, busy);
            end
        end
        for (int e = 0; e < ((expQ.size() > obsQ.size()) ? expQ.size() : obsQ.size()); e++) begin
            checks++;
            if (e >= obsQ.size() || e >= expQ.size() || obsQ[e] !== expQ[e]) begin
                errors++;
                $display("[TB] FAIL %s ev%0d got %h want %h (n_got=%0d n_want=%0d)", name, e,
                         (e < obsQ.size()) ? obsQ[e] : '0, (e < expQ.size()) ? expQ[e] : '0,
                         obsQ.size(), expQ.size());
            end
        end
    endtask

    task automatic test_reset_midrun();
        applyStimulus(10'd5, 3'd3, 1'b0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({we_k, addr_k, we_x, addr_x, acc_en, acc_first, we_o, rd_o, addr_o, busy, done, err} !== 55'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset outputs got=%h want=0",
                     {we_k, addr_k, we_x, addr_x, acc_en, acc_first, we_o, rd_o, addr_o, busy, done, err});
        end
        @(negedge clk);
        reset = 1'b0;
        obsQ.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL after_release got busy=%b events=%0d want busy=0 events=0", busy, obsQ.size());
        end
        test_conv("conv_after_reset", 10'd5, 3'd3);
    endtask

    initial begin
        reset = 1'b1;
        I = '0; K = '0; load_h = 1'b0; load_x = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load("load_k_5x3", 10'd5, 3'd3, 1'b0, 1'b0);
        test_load("load_x_5", 10'd5, 3'd3, 1'b1, 1'b0);
        test_conv("conv_5x3", 10'd5, 3'd3);
        test_conv("conv_4x1", 10'd4, 3'd1);
        test_conv("conv_3x3", 10'd3, 3'd3);
        test_bad_start("bad_k_gt_i", 10'd3, 3'd4);
        test_bad_start("bad_i_zero", 10'd0, 3'd1);
        test_bad_start("bad_k_zero", 10'd5, 3'd0);
        test_load("prio_loadh_start", 10'd3, 3'd4, 1'b0, 1'b1);
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
